// File: rtl/bcd_key_counter.sv
// bcd_key_counter: synchronised, debounced pushbutton stepping a two-digit BCD up/down counter with load
module bcd_key_counter #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_n,
  input  logic       up,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic [3:0] bcd_ones,
  output logic [3:0] bcd_tens,
  output logic       step,
  output logic       wrap
);
  localparam int W = DEBOUNCE_CYCLES > 1 ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [W-1:0] DMAX = W'(DEBOUNCE_CYCLES - 1);
  localparam logic [1:0] IDLE = 2'd0, PRESS_WAIT = 2'd1, PRESSED = 2'd2, RELEASE_WAIT = 2'd3;
  logic s1, ks, hit, press, wrap_c;
  logic [1:0] state;
  logic [W-1:0] dbc;
  logic [3:0] ones_n, tens_n, ld_ones, ld_tens;
  assign hit = dbc == DMAX;
  assign press = state == PRESS_WAIT && !ks && hit;
  assign ld_ones = load_val[3:0] > 4'd9 ? 4'd9 : load_val[3:0];
  assign ld_tens = load_val[7:4] > 4'd9 ? 4'd9 : load_val[7:4];
  // per-digit BCD step: the tens digit only moves when ones rolls over
  always_comb begin
    ones_n = up ? (bcd_ones == 4'd9 ? 4'd0 : bcd_ones + 4'd1)
                : (bcd_ones == 4'd0 ? 4'd9 : bcd_ones - 4'd1);
    tens_n = up ? (bcd_ones != 4'd9 ? bcd_tens : bcd_tens == 4'd9 ? 4'd0 : bcd_tens + 4'd1)
                : (bcd_ones != 4'd0 ? bcd_tens : bcd_tens == 4'd0 ? 4'd9 : bcd_tens - 4'd1);
    wrap_c = up ? (bcd_ones == 4'd9 && bcd_tens == 4'd9) : (bcd_ones == 4'd0 && bcd_tens == 4'd0);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b1;
      ks <= 1'b1;
      state <= IDLE;
      dbc <= '0;
      bcd_ones <= 4'd0;
      bcd_tens <= 4'd0;
      step <= 1'b0;
      wrap <= 1'b0;
    end else begin
      s1 <= key_n;
      ks <= s1;
      step <= press;
      wrap <= press && !load && wrap_c;
      if (load) begin
        bcd_ones <= ld_ones;
        bcd_tens <= ld_tens;
      end else if (press) begin
        bcd_ones <= ones_n;
        bcd_tens <= tens_n;
      end
      case (state)
        IDLE: if (!ks) begin
          state <= PRESS_WAIT;
          dbc <= '0;
        end
        PRESS_WAIT: if (ks) state <= IDLE;
          else if (hit) state <= PRESSED;
          else dbc <= dbc + W'(1);
        PRESSED: if (ks) begin
          state <= RELEASE_WAIT;
          dbc <= '0;
        end
        default: if (!ks) state <= PRESSED;
          else if (hit) state <= IDLE;
          else dbc <= dbc + W'(1);
      endcase
    end
  end
endmodule

// File: tb/tb_bcd_key_counter.sv
// tb_bcd_key_counter: directed and random key activity against a run-length debounce model
module tb_bcd_key_counter;
  localparam int D = 4;
  logic clk = 1'b0, rst, key_n, up, load;
  logic [7:0] load_val;
  logic [3:0] bcd_ones, bcd_tens;
  logic step, wrap;
  int n_assert = 0, n_fail = 0;
  logic m_s1, m_s2, lvl, e_step, e_wrap;
  int run, cnt;
  logic rk;
  always #5 clk = ~clk;
  bcd_key_counter #(.DEBOUNCE_CYCLES(D)) dut (
    .clk(clk), .rst(rst), .key_n(key_n), .up(up), .load(load), .load_val(load_val),
    .bcd_ones(bcd_ones), .bcd_tens(bcd_tens), .step(step), .wrap(wrap)
  );
  function automatic int clamp(input logic [3:0] d);
    return d > 4'd9 ? 9 : int'(d);
  endfunction
  // model: the accepted key level flips after D+1 consecutive synchronised samples disagreeing with it
  task automatic cyc(input logic r, input logic k, input logic u, input logic l, input logic [7:0] lv);
    logic pr;
    rst = r; key_n = k; up = u; load = l; load_val = lv;
    @(posedge clk);
    pr = 1'b0;
    if (r) begin
      m_s1 = 1'b1; m_s2 = 1'b1; lvl = 1'b1; run = 0; cnt = 0; e_step = 1'b0; e_wrap = 1'b0;
    end else begin
      if (m_s2 == lvl) run = 0;
      else begin
        run++;
        if (run == D + 1) begin
          lvl = m_s2;
          run = 0;
          pr = !m_s2;
        end
      end
      m_s2 = m_s1;
      m_s1 = k;
      e_step = pr;
      e_wrap = 1'b0;
      if (l) cnt = clamp(lv[7:4]) * 10 + clamp(lv[3:0]);
      else if (pr) begin
        if (u) begin e_wrap = cnt == 99; cnt = (cnt + 1) % 100; end
        else begin e_wrap = cnt == 0; cnt = (cnt + 99) % 100; end
      end
    end
    #1;
    n_assert++;
    assert (bcd_ones === 4'(cnt % 10)) else begin n_fail++; $error("FAIL ones got %0d want %0d", bcd_ones, cnt % 10); end
    n_assert++;
    assert (bcd_tens === 4'(cnt / 10)) else begin n_fail++; $error("FAIL tens got %0d want %0d", bcd_tens, cnt / 10); end
    n_assert++;
    assert (step === e_step) else begin n_fail++; $error("FAIL step got %b want %b", step, e_step); end
    n_assert++;
    assert (wrap === e_wrap) else begin n_fail++; $error("FAIL wrap got %b want %b", wrap, e_wrap); end
  endtask
  task automatic hold(input logic k, input logic u, input int n);
    repeat (n) cyc(1'b0, k, u, 1'b0, 8'h00);
  endtask
  task automatic press(input logic u);
    hold(1'b0, u, 10);
    hold(1'b1, u, 10);
  endtask
  initial begin
    repeat (3) cyc(1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
    hold(1'b1, 1'b1, 10);
    hold(1'b0, 1'b1, 60);
    hold(1'b1, 1'b1, 10);
    hold(1'b0, 1'b1, 3); hold(1'b1, 1'b1, 1); hold(1'b0, 1'b1, 3); hold(1'b1, 1'b1, 10);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 8'h99); press(1'b1);
    press(1'b0);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 8'h09); press(1'b1);
    press(1'b0);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 8'h4F); hold(1'b1, 1'b1, 2);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 8'hFA); hold(1'b1, 1'b1, 2);
    repeat (8) cyc(1'b0, 1'b0, 1'b1, 1'b1, 8'h27);
    hold(1'b1, 1'b1, 10);
    hold(1'b0, 1'b1, 3);
    repeat (2) cyc(1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
    hold(1'b0, 1'b1, 10);
    hold(1'b1, 1'b1, 10);
    rk = 1'b1;
    repeat (3000) begin
      if ($urandom_range(7) == 0) rk = ~rk;
      cyc($urandom_range(499) == 0, rk, 1'($urandom), $urandom_range(49) == 0, 8'($urandom));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
